// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day core: FSM states, BCD limits
// and the 24-hour to 12-hour display mapping.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam int ONES_MAX = 9;
  localparam int TENS_MAX = 5;
  localparam int HR_MAX   = 23;
  localparam int MIN_MAX  = 59;

  // 00 -> 12, 01..12 unchanged, 13..23 -> minus 12; returns {tens, ones}
  function automatic logic [7:0] to_12h(input logic [3:0] tens, input logic [3:0] ones);
    logic [4:0] h;
    h = 5'(tens) * 5'd10 + 5'(ones);
    if (h == 5'd0)       h = 5'd12;
    else if (h > 5'd12)  h = h - 5'd12;
    return (h >= 5'd10) ? {4'd1, 4'(h - 5'd10)} : {4'd0, 4'(h)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MODULUS-1 -> 00; carry is combinational
// so a chain of counters advances on the same edge.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clear,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry
);

  localparam logic [3:0] LAST_ONES = 4'((MODULUS - 1) % 10);
  localparam logic [3:0] LAST_TENS = 4'((MODULUS - 1) / 10);

  logic at_last;

  assign at_last = (ones == LAST_ONES) && (tens == LAST_TENS);
  assign carry   = inc && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (clear) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (inc) begin
      if (at_last) begin
        ones <= 4'd0;
        tens <= 4'd0;
      end else if (ones == 4'(ONES_MAX)) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_core_param.sv
// Time-of-day core: 1 Hz prescaler, BCD hh:mm:ss, 12/24-hour display and a
// two-button set mode with blinking of the field being adjusted.
//
//   state   | meaning
//   RUN     | time counts, inc key ignored
//   SET_HR  | time frozen, inc adds 1 to hours (no carry)
//   SET_MIN | time frozen, inc adds 1 to minutes; leaving clears seconds
module clock_core_param
  import clock_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BLINK_HZ    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  input  logic       mode_12h,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] hr_tens,
  output logic       pm,
  output logic [5:0] blank,
  output logic       tick_1s,
  output logic       setting
);

  localparam int PRESC_W    = $clog2(CLK_HZ);
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_W    = $clog2(BLINK_HALF + 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  state_t state, next_state;
  logic [SYNC_STAGES-1:0] mode_sync, inc_sync;
  logic mode_prev, inc_prev, mode_press, inc_press, set_inc;
  logic [PRESC_W-1:0] presc;
  logic [BLINK_W-1:0] blink_cnt;
  logic phase, blink_hr, blink_min;
  logic sec_clear, min_inc, hr_inc, sec_carry, min_carry, hr_carry;
  logic [3:0] s_o, s_t, m_o, m_t, h_o, h_t;
  logic [7:0] hr_disp;

  // synchronisers idle high (key released)
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_sync <= '1;
      inc_sync  <= '1;
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      mode_sync <= {mode_sync[SYNC_STAGES-2:0], btn_mode_n};
      inc_sync  <= {inc_sync[SYNC_STAGES-2:0], btn_inc_n};
      mode_prev <= ~mode_sync[SYNC_STAGES-1];
      inc_prev  <= ~inc_sync[SYNC_STAGES-1];
    end
  end

  assign mode_press = ~mode_sync[SYNC_STAGES-1] & ~mode_prev;
  assign inc_press  = ~inc_sync[SYNC_STAGES-1] & ~inc_prev;
  assign set_inc    = inc_press & ~mode_press;
  assign tick_1s    = (state == RUN) && (presc == PRESC_LAST);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= RUN;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    sec_clear  = 1'b0;
    min_inc    = 1'b0;
    hr_inc     = 1'b0;
    case (state)
      RUN: begin
        if (mode_press) next_state = SET_HR;
        min_inc = sec_carry;
        hr_inc  = min_carry;
      end
      SET_HR: begin
        if (mode_press) next_state = SET_MIN;
        hr_inc = set_inc;
      end
      SET_MIN: begin
        if (mode_press) begin
          next_state = RUN;
          sec_clear  = 1'b1;
        end
        min_inc = set_inc;
      end
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)                          presc <= '0;
    else if (state != RUN || presc == PRESC_LAST) presc <= '0;
    else                                   presc <= presc + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      blink_cnt <= BLINK_LAST;
      phase     <= 1'b0;
    end else if (blink_cnt == '0) begin
      blink_cnt <= BLINK_LAST;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt - 1'b1;
    end
  end

  bcd_mod_counter #(.MODULUS((TENS_MAX + 1) * 10)) u_sec (
    .clk(CLOCK_50), .rst_n(RESET_N), .inc(tick_1s), .clear(sec_clear),
    .ones(s_o), .tens(s_t), .carry(sec_carry)
  );

  bcd_mod_counter #(.MODULUS(MIN_MAX + 1)) u_min (
    .clk(CLOCK_50), .rst_n(RESET_N), .inc(min_inc), .clear(1'b0),
    .ones(m_o), .tens(m_t), .carry(min_carry)
  );

  // hours carry marks midnight; nothing downstream needs a day count
  bcd_mod_counter #(.MODULUS(HR_MAX + 1)) u_hr (
    .clk(CLOCK_50), .rst_n(RESET_N), .inc(hr_inc), .clear(1'b0),
    .ones(h_o), .tens(h_t), .carry(hr_carry)
  );

  assign hr_disp = mode_12h ? to_12h(h_t, h_o) : {h_t, h_o};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      {sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens} <= '0;
      pm        <= 1'b0;
      blink_hr  <= 1'b0;
      blink_min <= 1'b0;
      setting   <= 1'b0;
    end else begin
      sec_ones  <= s_o;
      sec_tens  <= s_t;
      min_ones  <= m_o;
      min_tens  <= m_t;
      hr_ones   <= hr_disp[3:0];
      hr_tens   <= hr_disp[7:4];
      pm        <= (h_t == 4'd2) || (h_t == 4'd1 && h_o >= 4'd2);
      blink_hr  <= phase && (state == SET_HR);
      blink_min <= phase && (state == SET_MIN);
      setting   <= (state != RUN);
    end
  end

  // leading-zero blank follows the mode input directly, so it is valid in reset
  assign blank = {blink_hr | (mode_12h & (hr_tens == 4'd0)) | (hr_carry & 1'b0),
                  blink_hr, blink_min, blink_min, 2'b00};

endmodule
